// File: rtl/fifo_emu_pkg.sv
// Shared constants, types and helpers for the FT60x 245-sync FIFO slave emulator.
package fifo_emu_pkg;

  // One 4 KB FT600 buffer expressed in 32-bit words.
  localparam int DEPTH_DEF     = 1024;
  localparam int FILL_DIV_DEF  = 4;
  localparam int DRAIN_DIV_DEF = 4;

  // The emulated chip always presents all four byte lanes as valid.
  localparam logic [3:0] BE_ALL = 4'hF;

  // Pattern-error counter width and its saturation value.
  localparam int               ERR_W   = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Selects which side of the occupancy counter the host-rate divider feeds.
  // SOURCE: host fills (divider increments), master reads decrement, flag = empty.
  // SINK:   master writes increment, host drains (divider decrements), flag = full.
  typedef enum logic {
    OCC_SOURCE = 1'b0,
    OCC_SINK   = 1'b1
  } occ_role_e;

  // Expand a 4-bit byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_emu_occ.sv
// Emulated chip-buffer occupancy: host-rate divider, saturating up/down
// counter and a registered status flag (empty for source, full for sink).
module fifo_emu_occ
  import fifo_emu_pkg::*;
#(
  parameter int        DEPTH = DEPTH_DEF,
  parameter int        DIV   = 4,
  parameter occ_role_e ROLE  = OCC_SOURCE,
  parameter int        CNT_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rate_en,
  input  logic xfer,
  input  logic clr,
  output logic flag
);

  // A divide-by-1 still needs a one-bit counter to keep the logic uniform.
  localparam int                 DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   OCC_MAX  = CNT_W'(DEPTH);
  // Flag value that matches an empty buffer: source reports empty, sink not full.
  localparam logic               FLAG_RST = (ROLE == OCC_SOURCE);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             flag_q, flag_d;
  logic             inc_ev, dec_ev;

  // Host-rate divider: one tick every DIV enabled cycles, holds when disabled.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (rate_en) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Occupancy update: flush wins, coincident up/down cancel, otherwise saturate at both ends.
  always_comb begin
    inc_ev = (ROLE == OCC_SOURCE) ? tick : xfer;
    dec_ev = (ROLE == OCC_SOURCE) ? xfer : tick;
    occ_d  = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (inc_ev && dec_ev) begin
      occ_d = occ_q;
    end else if (inc_ev && (occ_q < OCC_MAX)) begin
      occ_d = occ_q + 1'b1;
    end else if (dec_ev && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
    flag_d = (ROLE == OCC_SOURCE) ? (occ_d == '0) : (occ_d == OCC_MAX);
  end

  // State registers; the flag is computed from the next occupancy so it tracks it without lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      occ_q  <= '0;
      flag_q <= FLAG_RST;
    end else begin
      div_q  <= div_d;
      occ_q  <= occ_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/fifo_slv_emu.sv
// FT60x 245-synchronous FIFO slave emulator: incrementing-pattern source
// toward the master and pattern-checking sink from the master.
module fifo_slv_emu
  import fifo_emu_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int FILL_DIV  = FILL_DIV_DEF,
  parameter int DRAIN_DIV = DRAIN_DIV_DEF,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic        fifoClk,
  input  logic        fifoRstn,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        oe_n,
  input  logic        siwu_n,
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        data_oe,
  output logic        rxf_n,
  output logic        txe_n,
  input  logic        src_en,
  input  logic        snk_en,
  output logic [31:0] tx_word_cnt,
  output logic [31:0] rx_word_cnt,
  output logic [15:0] err_cnt,
  output logic        ovf,
  output logic        proto_err
);

  logic             rd_ok;
  logic             wr_req;
  logic             wr_ok;
  logic             flush;
  logic [31:0]      cmp_mask;
  logic             mismatch;

  logic [31:0]      src_pat_q, src_pat_d;
  logic [31:0]      exp_pat_q, exp_pat_d;
  logic [31:0]      tx_cnt_q, tx_cnt_d;
  logic [31:0]      rx_cnt_q, rx_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             ovf_q, ovf_d;
  logic             proto_q, proto_d;
  logic             data_oe_q, data_oe_d;

  // Bus handshake decode; wr_n low blocks reads so a bus fight never transfers data.
  always_comb begin
    rd_ok    = !rd_n && !oe_n && !rxf_n && wr_n;
    wr_req   = !wr_n;
    wr_ok    = wr_req && !txe_n && oe_n;
    flush    = !siwu_n;
    cmp_mask = byte_mask(be_i);
    mismatch = ((data_i ^ exp_pat_q) & cmp_mask) != 32'h0;
  end

  // Source side: advance the pattern and the delivered-word count per accepted read.
  always_comb begin
    src_pat_d = src_pat_q;
    tx_cnt_d  = tx_cnt_q;
    if (rd_ok) begin
      src_pat_d = src_pat_q + 32'd1;
      tx_cnt_d  = tx_cnt_q + 32'd1;
    end
  end

  // Sink side: count, check enabled lanes and resync the expected pattern on a miss.
  always_comb begin
    exp_pat_d = exp_pat_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    if (wr_ok) begin
      rx_cnt_d = rx_cnt_q + 32'd1;
      if (mismatch) begin
        exp_pat_d = data_i + 32'd1;
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end else begin
        exp_pat_d = exp_pat_q + 32'd1;
      end
    end
  end

  // Sticky protocol flags and the one-cycle pad turnaround.
  always_comb begin
    ovf_d     = ovf_q || (wr_req && txe_n);
    proto_d   = proto_q || (wr_req && !oe_n);
    data_oe_d = !oe_n;
  end

  // Datapath and status registers; reset abandons any transfer in flight.
  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      src_pat_q <= '0;
      exp_pat_q <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      src_pat_q <= src_pat_d;
      exp_pat_q <= exp_pat_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      proto_q   <= proto_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Source buffer: host fills at FILL_DIV, master reads drain, rxf_n is the empty flag.
  fifo_emu_occ #(
    .DEPTH (DEPTH),
    .DIV   (FILL_DIV),
    .ROLE  (OCC_SOURCE),
    .CNT_W (CNT_W)
  ) u_src_occ (
    .clk     (fifoClk),
    .rst_n   (fifoRstn),
    .rate_en (src_en),
    .xfer    (rd_ok),
    .clr     (1'b0),
    .flag    (rxf_n)
  );

  // Sink buffer: master writes fill, host drains at DRAIN_DIV, siwu_n flushes, txe_n is the full flag.
  fifo_emu_occ #(
    .DEPTH (DEPTH),
    .DIV   (DRAIN_DIV),
    .ROLE  (OCC_SINK),
    .CNT_W (CNT_W)
  ) u_snk_occ (
    .clk     (fifoClk),
    .rst_n   (fifoRstn),
    .rate_en (snk_en),
    .xfer    (wr_ok),
    .clr     (flush),
    .flag    (txe_n)
  );

  // The read word is the live pattern so it is valid in the cycle rd_n is sampled.
  assign data_o      = src_pat_q;
  assign be_o        = BE_ALL;
  assign data_oe     = data_oe_q;
  assign tx_word_cnt = tx_cnt_q;
  assign rx_word_cnt = rx_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign ovf         = ovf_q;
  assign proto_err   = proto_q;

endmodule

// File: doc/fifo_slv_emu.md
Name: fifo_slv_emu

Overview:
- Synthesizable FT60x 245-synchronous-FIFO slave emulator: the chip end of the 32-bit FIFO bus that the FIFO master drives.
- Provides an incrementing-pattern data source toward the master (RXF_N/OE_N/RD_N read path) and a pattern-checking sink from the master (TXE_N/WR_N write path).
- Models finite chip buffer occupancy with host-side fill/drain rates.
- Sits in the on-board loopback/BIST build and the simulation top in place of the FT600 pads, so the master datapath and FSM run without a USB host.

Parameters:
DEPTH, 1024, emulated buffer depth per direction in 32-bit words (one 4 KB FT600 buffer); power of two, >=4
FILL_DIV, 4, host->chip fill rate: source occupancy +1 every FILL_DIV cycles while src_en
DRAIN_DIV, 4, chip->host drain rate: sink occupancy -1 every DRAIN_DIV cycles while snk_en
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived)

Ports:
fifoClk  in  1  bus clock, all logic rising-edge
fifoRstn  in  1  asynchronous active-low reset
wr_n  in  1  master write strobe
rd_n  in  1  master read strobe
oe_n  in  1  master output-enable (slave drives bus when low)
siwu_n  in  1  send-immediate; flushes sink buffer
data_i  in  32  bus data from master
be_i  in  4  byte enables from master
data_o  out  32  bus data to master
be_o  out  4  byte enables to master (always 4'hF)
data_oe  out  1  pad tristate enable for data_o/be_o
rxf_n  out  1  low = source has words for master
txe_n  out  1  low = sink can accept words
src_en  in  1  enable source fill
snk_en  in  1  enable sink drain
tx_word_cnt  out  32  words delivered to master (wraps)
rx_word_cnt  out  32  words accepted from master (wraps)
err_cnt  out  16  sink pattern mismatches (saturates at 16'hFFFF)
ovf  out  1  sticky: write attempted while txe_n high
proto_err  out  1  sticky: wr_n and oe_n both low in same cycle

Behaviour:
- Reset (async, fifoRstn low): src_occ=0, snk_occ=0, src_pat=0, exp_pat=0, dividers=0; rxf_n=1, txe_n=0, data_oe=0, data_o=0, be_o=4'hF, all counters 0, ovf=0, proto_err=0. Reset mid-transfer abandons the transfer; no partial state survives.
- Read accept (rising edge): rd_ok = !rd_n & !oe_n & !rxf_n & wr_n.
  - On rd_ok: src_pat+1, src_occ-1, tx_word_cnt+1.
  - data_o = src_pat combinationally, so the word is valid in the same cycle RD_N is sampled.
- data_oe: register of ~oe_n (one-cycle turnaround after OE_N falls, releases one cycle after OE_N rises).
- Read strobe ignored (no count, no pattern advance) when rxf_n=1.
- Source fill: divider tick every FILL_DIV cycles while src_en; src_occ+1 if src_occ<DEPTH.
- Simultaneous fill tick and rd_ok: src_occ unchanged.
- rxf_n is registered, = (next src_occ==0): rises the cycle after the last word is consumed; falls the cycle after the first fill.
- Write accept: wr_ok = !wr_n & !txe_n & oe_n.
  - On wr_ok: snk_occ+1, rx_word_cnt+1.
  - Compare data_i with exp_pat on the bytes enabled by be_i.
  - Mismatch: err_cnt+1 (saturating), exp_pat <= data_i+1 (resync).
  - Match: exp_pat+1.
  - be_i=0: the word is counted but not compared.
- Write with txe_n=1: dropped, ovf<=1.
- Write with oe_n low: dropped, proto_err<=1. No acceptance of either direction that cycle.
- Sink drain: tick every DRAIN_DIV cycles while snk_en; snk_occ-1 if >0.
- Simultaneous drain tick and wr_ok: snk_occ unchanged.
- siwu_n sampled low: snk_occ<=0 next cycle. Takes priority over wr_ok in that cycle; the word is still counted and checked.
- txe_n is registered, = (next snk_occ==DEPTH).
- All 32-bit counters and patterns wrap modulo 2^32; occupancies never exceed DEPTH or go below 0.

Decomposition:
- Shared package fifo_emu_pkg: DEPTH default, be_o constant 4'hF, err_cnt width 16.
- One natural sub-module: fifo_emu_occ. It is instantiated twice (source, sink) and contains the rate divider, the occupancy up/down counter with saturation, and the registered flag output (empty for the source, full for the sink).

Test Plan:
- Reset, src_en=1, FILL_DIV=4 -> rxf_n falls by cycle 5; hold oe_n low, then rd_n low for 8 cycles -> data_o 0..7 sampled, tx_word_cnt=8, src_pat=8.
- src_en=0 with 3 words filled; read 5 cycles -> exactly 3 words, rxf_n=1 the cycle after the 3rd, tx_word_cnt=3.
- snk_en=0, DEPTH=4; write 0,1,2,3,4 -> txe_n=1 after the 4th, 5th dropped, ovf=1, rx_word_cnt=4, err_cnt=0.
- Write 0,1,5,6 with be_i=F, then 7 with be_i=4'h1 -> err_cnt=1, exp_pat=8.
- wr_n and oe_n low together -> proto_err=1, rx_word_cnt and tx_word_cnt unchanged.
- snk_occ=4 (full), pulse siwu_n -> snk_occ=0, txe_n low the next cycle. Then assert fifoRstn low mid-read -> all outputs at reset values immediately.
